// File: rtl/stream_mux_nx1.sv
// N-channel packet-locked stream mux with a registered output stage.
// Define MUX_RR_EN for round-robin arbitration; otherwise sel picks the channel.
module stream_mux_nx1 #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [SEL_W-1:0]      cur_ch
);

    typedef enum logic [0:0] {
        IDLE,
        LOCK
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   cand;
    logic               cand_ok;
    logic [WIDTH-1:0]   ch_data;
    logic               ch_valid;
    logic               ch_last;
    logic               room;
    logic               accept;

    // Route the locked channel's beat towards the output register
    always_comb begin
        ch_data  = '0;
        ch_valid = 1'b0;
        ch_last  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (cur_ch == SEL_W'(k)) begin
                ch_data  = in_data[k*WIDTH +: WIDTH];
                ch_valid = in_valid[k];
                ch_last  = in_last[k];
            end
        end
    end

    assign room   = !out_valid || out_ready;
    assign accept = (state == LOCK) && ch_valid && room;

    // Only the locked channel sees ready, and only when the output reg can take a beat
    always_comb begin
        in_ready = '0;
        if (state == LOCK) begin
            for (int k = 0; k < N_CH; k++) begin
                in_ready[k] = (cur_ch == SEL_W'(k)) && room;
            end
        end
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;
    logic             sel_unused;

    assign sel_unused = ^sel;

    // First valid channel after the last granted one, wrapping around
    always_comb begin
        int idx;
        idx     = 0;
        cand    = '0;
        cand_ok = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!cand_ok && in_valid[idx]) begin
                cand_ok = 1'b1;
                cand    = SEL_W'(idx);
            end
        end
    end
`else
    // Requested channel; out-of-range selects never match and so never grant
    always_comb begin
        cand    = sel;
        cand_ok = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                cand_ok = in_valid[k];
            end
        end
    end
`endif

    // Grant/lock FSM: hold the channel until its last beat is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cur_ch <= '0;
`ifdef MUX_RR_EN
            rr_ptr <= SEL_W'(N_CH - 1);
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (cand_ok) begin
                        state  <= LOCK;
                        busy   <= 1'b1;
                        cur_ch <= cand;
`ifdef MUX_RR_EN
                        rr_ptr <= cand;
`endif
                    end
                end
                LOCK: begin
                    if (accept && ch_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Output register: load on accept, drop valid once the sink has taken it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= ch_data;
            out_last  <= ch_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Scoreboard bench for stream_mux_nx1 (N_CH=4 main DUT, N_CH=3 boundary DUT).
// Per-channel source queues drive beats; a monitor pops expected beats on output.
module tb_stream_mux_nx1;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic [1:0]  cur_ch;

    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_last3;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_last3;
    logic        out_ready3;
    logic        busy3;
    logic [1:0]  cur_ch3;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] src_q [4][$];
    logic [8:0] exp_q [$];
    int         out_cyc [$];

    stream_mux_nx1 #(.N_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready), .busy(busy),
        .cur_ch(cur_ch)
    );

    stream_mux_nx1 #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_last(out_last3), .out_ready(out_ready3), .busy(busy3),
        .cur_ch(cur_ch3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input int ch, input logic [7:0] d0,
                            input int n, input bit to_sb);
        logic [8:0] b;
        for (int i = 0; i < n; i++) begin
            b = {(i == n - 1), 8'(d0 + 8'(i))};
            src_q[ch].push_back(b);
            if (to_sb) exp_q.push_back(b);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < 4; k++) begin
            if (src_q[k].size() > 0) begin
                in_valid[k]          = 1'b1;
                in_data[k*8 +: 8]    = src_q[k][0][7:0];
                in_last[k]           = src_q[k][0][8];
            end else begin
                in_valid[k]          = 1'b0;
                in_last[k]           = 1'b0;
            end
        end
    endtask

    // Source model: handshake sampled mid-cycle, queue advanced after the edge
    initial begin
        logic [3:0] fire;
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            fire = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            end
            drive_src();
        end
    end

    // Monitor: every transferred output beat must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [8:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra got=%0h want=none", {out_last, out_data});
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_data} !== e) begin
                    bad++;
                    $display("FAIL sb_beat got=%0h want=%0h",
                             {out_last, out_data}, e);
                end
            end
            out_cyc.push_back(cyc);
        end
    end

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0) || busy || out_valid;
        for (int k = 0; k < 4; k++) if (src_q[k].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (pending() && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int t0;
        int n;
        logic [7:0] held;

        rst_n      = 1'b0;
        sel        = 2'd0;
        out_ready  = 1'b1;
        sel3       = 2'd0;
        in_data3   = '0;
        in_valid3  = '0;
        in_last3   = '0;
        out_ready3 = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_cur_ch",    32'(cur_ch),    32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 3-beat packet on ch2 with sel=2
        @(posedge clk);
        #2;
        sel = 2'd2;
        out_cyc.delete();
        push_pkt(2, 8'hA1, 3, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_valid[2] && n < 20);
        t0 = cyc;
        chk("a_idle_busy", 32'(busy), 32'd0);
        chk("a_idle_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("a_lock_busy", 32'(busy), 32'd1);
        chk("a_lock_ch", 32'(cur_ch), 32'd2);
        chk("a_lock_ready", 32'(in_ready), 32'b0100);
        @(negedge clk);
        @(negedge clk);
        chk("a_busy_mid", 32'(busy), 32'd1);
        @(negedge clk);
        chk("a_busy_end", 32'(busy), 32'd0);
        chk("a_ready_end", 32'(in_ready), 32'd0);
        wait_drain("a");
        chk("a_nbeats", 32'(out_cyc.size()), 32'd3);
        chk("a_lat0", 32'(out_cyc[0] - t0), 32'd2);
        chk("a_lat1", 32'(out_cyc[1] - t0), 32'd3);
        chk("a_lat2", 32'(out_cyc[2] - t0), 32'd4);

`ifndef MUX_RR_EN
        // sel changed mid-packet: ch2 completes, one bubble, then ch0
        @(posedge clk);
        #2;
        out_cyc.delete();
        sel = 2'd2;
        push_pkt(2, 8'hB1, 3, 1'b1);
        push_pkt(0, 8'hC1, 2, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 20);
        @(posedge clk);
        #2 sel = 2'd0;
        wait_drain("b");
        chk("b_nbeats", 32'(out_cyc.size()), 32'd5);
        chk("b_b_gap", 32'(out_cyc[2] - out_cyc[0]), 32'd2);
        chk("b_bubble", 32'(out_cyc[3] - out_cyc[2]), 32'd2);
        chk("b_cur_ch", 32'(cur_ch), 32'd0);
`endif

        // Backpressure for 3 cycles in the middle of a ch1 packet
        @(posedge clk);
        #2;
        sel = 2'd1;
        push_pkt(1, 8'hD1, 4, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        @(posedge clk);
        #1 out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data", 32'(out_data), 32'(held));
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain("bp");

        // Reset while a packet is locked and a beat is held
        @(posedge clk);
        #1 out_ready = 1'b0;
        sel = 2'd3;
        push_pkt(3, 8'hE1, 3, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && busy) && n < 20);
        chk("mr_pre_lock", 32'(busy && out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cur_ch", 32'(cur_ch), 32'd0);
        src_q[3].delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mr_after_valid", 32'(out_valid), 32'd0);
        chk("mr_after_busy", 32'(busy), 32'd0);

`ifdef MUX_RR_EN
        // Round-robin over 1-beat packets: 0,1,2,3,0
        @(posedge clk);
        #2;
        out_cyc.delete();
        push_pkt(0, 8'h10, 1, 1'b0);
        push_pkt(1, 8'h21, 1, 1'b0);
        push_pkt(2, 8'h32, 1, 1'b0);
        push_pkt(3, 8'h43, 1, 1'b0);
        push_pkt(0, 8'h14, 1, 1'b0);
        exp_q.push_back(9'h110);
        exp_q.push_back(9'h121);
        exp_q.push_back(9'h132);
        exp_q.push_back(9'h143);
        exp_q.push_back(9'h114);
        wait_drain("rr");
        chk("rr_nbeats", 32'(out_cyc.size()), 32'd5);
        chk("rr_cur_ch", 32'(cur_ch), 32'd0);
`else
        // N_CH=3 with out-of-range sel: never grants
        @(posedge clk);
        #1;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        in_last3  = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("n3_busy", 32'(busy3), 32'd0);
            chk("n3_ready", 32'(in_ready3), 32'd0);
        end
        @(posedge clk);
        #1 sel3 = 2'd2;
        @(posedge clk);
        @(negedge clk);
        chk("n3_grant_busy", 32'(busy3), 32'd1);
        chk("n3_grant_ch", 32'(cur_ch3), 32'd2);
`endif

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
